// File: rtl/lut_inverse_search.sv
// lut_inverse_search: successive-approximation inverse of a monotonic table with fractional interpolation
module lut_inverse_search #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int FRAC_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tbl_we,
    input  logic [ADDR_W-1:0]        tbl_addr,
    input  logic [DATA_W-1:0]        tbl_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W+FRAC_W-1:0] x_out,
    output logic                     under,
    output logic                     over
);
    localparam int D  = 2 ** ADDR_W;
    localparam int W  = DATA_W + FRAC_W;
    localparam int BW = $clog2(ADDR_W + 1);
    localparam logic [FRAC_W-1:0] FMAX = '1;
    localparam logic [ADDR_W-1:0] IMAX = '1;

    typedef enum logic [1:0] {IDLE, SEARCH, FRAC, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] t [D];
    logic [DATA_W-1:0] y_r;
    logic [ADDR_W-1:0] idx, cand, idx_n;
    logic [BW-1:0]     b;
    logic [W-1:0]      d, dy, q;
    logic [FRAC_W-1:0] frac;
    logic              is_under, is_over;

    always_comb begin
        cand     = idx | (ADDR_W'(1) << b);
        idx_n    = idx + ADDR_W'(1);
        d        = W'(t[idx_n]) - W'(t[idx]);
        dy       = W'(y_r) - W'(t[idx]);
        // a zero step only arises from a non-monotonic table; avoid an X divide
        q        = (d == '0) ? W'(FMAX) : (dy << FRAC_W) / d;
        frac     = (q > W'(FMAX)) ? FMAX : q[FRAC_W-1:0];
        is_under = t[0] > y_r;
        is_over  = !is_under && idx == IMAX;
    end

    always_ff @(posedge clk)
        if (tbl_we && state == IDLE) t[tbl_addr] <= tbl_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            under     <= 1'b0;
            over      <= 1'b0;
            y_r       <= '0;
            idx       <= '0;
            b         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    y_r      <= y_in;
                    idx      <= '0;
                    b        <= BW'(ADDR_W - 1);
                    in_ready <= 1'b0;
                    state    <= SEARCH;
                end
                SEARCH: begin
                    if (t[cand] <= y_r) idx <= cand;
                    if (b == '0) state <= FRAC;
                    else b <= b - BW'(1);
                end
                FRAC: begin
                    under     <= is_under;
                    over      <= is_over;
                    x_out     <= is_under ? '0 : is_over ? {idx, {FRAC_W{1'b0}}} : {idx, frac};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
